// File: rtl/param_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// param_fifo_ctrl_if
//   Handshake and status bundle between a producer/consumer and the
//   param_fifo_ctrl FIFO. Clock and reset are not part of the bundle.
//
//   Parameters
//     FIFOWIDTH  data word width
//     ADDRWIDTH  pointer width, DEPTH = 2**ADDRWIDTH
//
//   Signals (direction seen from the FIFO, i.e. the slave modport)
//     write, read, clear_flags   in   push / pop request, sticky flag clear
//     data_in                    in   write data
//     data_out, data_valid       out  read data and its qualifier
//     full, empty                out  Count == DEPTH / Count == 0
//     almost_full, almost_empty  out  threshold decodes of Count
//     count                      out  occupancy 0..DEPTH
//     rd_ptr, wr_ptr             out  next read / write address
//     ov, un                     out  sticky overflow / underflow
// -----------------------------------------------------------------------------
interface param_fifo_ctrl_if #(
  parameter int FIFOWIDTH = 32,
  parameter int ADDRWIDTH = 4
);
  logic                 write;
  logic                 read;
  logic                 clear_flags;
  logic [FIFOWIDTH-1:0] data_in;
  logic [FIFOWIDTH-1:0] data_out;
  logic                 data_valid;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [ADDRWIDTH:0]   count;
  logic [ADDRWIDTH-1:0] rd_ptr;
  logic [ADDRWIDTH-1:0] wr_ptr;
  logic                 ov;
  logic                 un;

  modport master (
    output write, read, clear_flags, data_in,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
           count, rd_ptr, wr_ptr, ov, un
  );

  modport slave (
    input  write, read, clear_flags, data_in,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
           count, rd_ptr, wr_ptr, ov, un
  );
endinterface

// File: rtl/param_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// param_fifo_ctrl
//   Parametrised single-clock FIFO with occupancy count, almost-full /
//   almost-empty thresholds and sticky overflow / underflow flags.
//   A read and a write may be accepted in the same cycle; a push into a
//   full FIFO succeeds when a pop is accepted alongside it.
//
//   Build option
//     FIFO_FWFT_EN  defined   : first-word fall-through, data_out shows the
//                               head word whenever the FIFO is not empty and
//                               read acknowledges it.
//                   undefined : standard mode, data_out is registered on an
//                               accepted read, data_valid pulses one cycle.
//
//   Ports
//     clk_i     in   system clock, rising edge
//     rst_n_i   in   asynchronous reset, active low
//     bus       slave modport of param_fifo_ctrl_if (see that file)
// -----------------------------------------------------------------------------
module param_fifo_ctrl #(
  parameter int FIFOWIDTH     = 32,
  parameter int ADDRWIDTH     = 4,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  param_fifo_ctrl_if.slave   bus
);

  localparam int DEPTH = 1 << ADDRWIDTH;
  localparam logic [ADDRWIDTH:0]   CNT_FULL   = (ADDRWIDTH+1)'(DEPTH);
  localparam logic [ADDRWIDTH:0]   CNT_AFULL  = (ADDRWIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDRWIDTH:0]   CNT_AEMPTY = (ADDRWIDTH+1)'(AEMPTY_THRESH);
  localparam logic [ADDRWIDTH:0]   CNT_ONE    = (ADDRWIDTH+1)'(1);
  localparam logic [ADDRWIDTH-1:0] PTR_ONE    = ADDRWIDTH'(1);

  // storage is intentionally not reset; pointers/count define what is live
  logic [FIFOWIDTH-1:0] mem_q [DEPTH];

  logic [ADDRWIDTH:0]   count_q,  count_d;
  logic [ADDRWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                 ov_q,     ov_d;
  logic                 un_q,     un_d;

  logic full, empty;
  logic rd_ok, wr_ok;
  logic ov_set, un_set;

  // status decodes come from registered count only
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CNT_FULL);
  end

  // a pop frees a slot in the same edge, so a full FIFO can still take a push
  always_comb begin
    rd_ok  = bus.read  & ~empty;
    wr_ok  = bus.write & (~full | rd_ok);
    ov_set = bus.write & full & ~rd_ok;
    un_set = bus.read  & empty;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ov_d     = ov_q;
    un_d     = un_q;

    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // clear first so a simultaneous set condition keeps the flag high
    if (bus.clear_flags) begin
      ov_d = 1'b0;
      un_d = 1'b0;
    end
    if (ov_set) ov_d = 1'b1;
    if (un_set) un_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      ov_q     <= 1'b0;
      un_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      ov_q     <= ov_d;
      un_q     <= un_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wr_ptr_q] <= bus.data_in;
  end

`ifdef FIFO_FWFT_EN
  // head word is visible straight from storage; forced to 0 while empty so the
  // output reads 0 out of reset
  always_comb begin
    bus.data_out   = empty ? '0 : mem_q[rd_ptr_q];
    bus.data_valid = ~empty;
  end
`else
  logic [FIFOWIDTH-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;

  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = rd_ok;
    if (rd_ok) data_out_d = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  always_comb begin
    bus.data_out   = data_out_q;
    bus.data_valid = data_valid_q;
  end
`endif

  always_comb begin
    bus.full         = full;
    bus.empty        = empty;
    bus.almost_full  = (count_q >= CNT_AFULL);
    bus.almost_empty = (count_q <= CNT_AEMPTY);
    bus.count        = count_q;
    bus.rd_ptr       = rd_ptr_q;
    bus.wr_ptr       = wr_ptr_q;
    bus.ov           = ov_q;
    bus.un           = un_q;
  end

endmodule

// File: tb/tb_param_fifo_ctrl.sv
module tb_param_fifo_ctrl;

  localparam int W = 32;
  localparam int A = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  param_fifo_ctrl_if #(.FIFOWIDTH(W), .ADDRWIDTH(A)) bus ();

  param_fifo_ctrl #(
    .FIFOWIDTH(W), .ADDRWIDTH(A), .AFULL_THRESH(14), .AEMPTY_THRESH(2)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock, then sample 1 ns after the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    bus.write   = 1'b1;
    bus.data_in = d;
    cyc();
    bus.write   = 1'b0;
  endtask

  // pop one word and check it is the expected head
  task automatic pop_chk(input string tag, input logic [W-1:0] exp);
`ifdef FIFO_FWFT_EN
    chk({tag, "_dv"}, 64'(bus.data_valid), 64'd1);
    chk(tag, 64'(bus.data_out), 64'(exp));
    bus.read = 1'b1;
    cyc();
    bus.read = 1'b0;
`else
    bus.read = 1'b1;
    cyc();
    bus.read = 1'b0;
    chk({tag, "_dv"}, 64'(bus.data_valid), 64'd1);
    chk(tag, 64'(bus.data_out), 64'(exp));
`endif
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_count"}, 64'(bus.count), 64'd0);
    chk({tag, "_empty"}, 64'(bus.empty), 64'd1);
    chk({tag, "_full"},  64'(bus.full),  64'd0);
    chk({tag, "_rdptr"}, 64'(bus.rd_ptr), 64'd0);
    chk({tag, "_wrptr"}, 64'(bus.wr_ptr), 64'd0);
    chk({tag, "_dout"},  64'(bus.data_out), 64'd0);
    chk({tag, "_dv"},    64'(bus.data_valid), 64'd0);
    chk({tag, "_ov"},    64'(bus.ov), 64'd0);
    chk({tag, "_un"},    64'(bus.un), 64'd0);
  endtask

  initial begin
    bus.write       = 1'b0;
    bus.read        = 1'b0;
    bus.clear_flags = 1'b0;
    bus.data_in     = '0;

    // reset state
    #12;
    reset_chk("rst");
    chk("rst_aempty", 64'(bus.almost_empty), 64'd1);
    chk("rst_afull",  64'(bus.almost_full),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // 1: fill with 1..16, check thresholds along the way, drain in order
    for (int i = 1; i <= 16; i++) begin
      push(W'(i));
      chk($sformatf("fill_count%0d", i), 64'(bus.count), 64'(i));
      chk($sformatf("fill_afull%0d", i), 64'(bus.almost_full), 64'(i >= 14));
      chk($sformatf("fill_aempty%0d", i), 64'(bus.almost_empty), 64'(i <= 2));
    end
    chk("fill_full",  64'(bus.full), 64'd1);
    chk("fill_wrptr", 64'(bus.wr_ptr), 64'd0);
    for (int i = 1; i <= 16; i++)
      pop_chk($sformatf("drain%0d", i), W'(i));
    chk("drain_empty", 64'(bus.empty), 64'd1);
    chk("drain_rdptr", 64'(bus.rd_ptr), 64'd0);
    chk("drain_un",    64'(bus.un), 64'd0);
`ifndef FIFO_FWFT_EN
    cyc();
    chk("dv_one_cycle", 64'(bus.data_valid), 64'd0);
    chk("dout_hold",    64'(bus.data_out), 64'h10);
`endif

    // 2: overflow on full, set wins over clear, then clear
    for (int i = 1; i <= 16; i++) push(W'(i));
    push(W'(32'hDEAD));
    chk("ov_set",   64'(bus.ov), 64'd1);
    chk("ov_count", 64'(bus.count), 64'd16);
    chk("ov_wrptr", 64'(bus.wr_ptr), 64'd0);
    bus.clear_flags = 1'b1;
    push(W'(32'hDEAD));
    chk("ov_set_beats_clear", 64'(bus.ov), 64'd1);
    cyc();
    bus.clear_flags = 1'b0;
    chk("ov_cleared", 64'(bus.ov), 64'd0);
    pop_chk("ov_head", W'(1));
    push(W'(32'h11));   // full again: 2..16, 0x11

    // 3: simultaneous read+write on full
    chk("rw_full_pre", 64'(bus.full), 64'd1);
`ifdef FIFO_FWFT_EN
    chk("rw_head", 64'(bus.data_out), 64'd2);
`endif
    bus.read = 1'b1;
    push(W'(32'hBEEF));
    bus.read = 1'b0;
`ifndef FIFO_FWFT_EN
    chk("rw_head", 64'(bus.data_out), 64'd2);
`endif
    chk("rw_count", 64'(bus.count), 64'd16);
    chk("rw_ov",    64'(bus.ov), 64'd0);
    for (int i = 3; i <= 16; i++) pop_chk($sformatf("rw_out%0d", i), W'(i));
    pop_chk("rw_out_11", W'(32'h11));
    pop_chk("rw_beef16", W'(32'hBEEF));
    chk("rw_empty", 64'(bus.empty), 64'd1);

    // 4: read+write on empty
    bus.read = 1'b1;
    push(W'(32'h55));
    bus.read = 1'b0;
    chk("un_set",   64'(bus.un), 64'd1);
    chk("un_count", 64'(bus.count), 64'd1);
`ifdef FIFO_FWFT_EN
    chk("un_dv", 64'(bus.data_valid), 64'd1);
`else
    chk("un_dv", 64'(bus.data_valid), 64'd0);
`endif
    pop_chk("un_word", W'(32'h55));
    chk("un_sticky", 64'(bus.un), 64'd1);
    bus.clear_flags = 1'b1;
    cyc();
    bus.clear_flags = 1'b0;
    chk("un_cleared", 64'(bus.un), 64'd0);

    // 5: async reset mid-cycle after 8 writes
    for (int i = 0; i < 8; i++) push(W'(32'h100 + i));
    chk("mid_count", 64'(bus.count), 64'd8);
    pop_chk("mid_head", W'(32'h100));
    bus.write   = 1'b1;
    bus.data_in = W'(32'h999);
    #2;
    rst_n = 1'b0;
    #1;
    bus.write = 1'b0;
    reset_chk("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    push(W'(32'h77));
    chk("post_wrptr", 64'(bus.wr_ptr), 64'd1);
    pop_chk("post_addr0", W'(32'h77));

`ifdef FIFO_FWFT_EN
    // 6: fall-through of a single word
    push(W'(32'hA5));
    chk("fwft_dv",    64'(bus.data_valid), 64'd1);
    chk("fwft_dout",  64'(bus.data_out), 64'hA5);
    bus.read = 1'b1;
    cyc();
    bus.read = 1'b0;
    chk("fwft_empty", 64'(bus.empty), 64'd1);
    chk("fwft_dv0",   64'(bus.data_valid), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
